// File: rtl/sine_checksum_ctrl.sv
// Checksum sequencer: walks the sample BRAM, streams each byte to the CORDIC
// as a phase, sums the sine results and flags SUCCESS/ERROR at the end.
module sine_checksum_ctrl #(
  parameter int NUM_SAMPLES = 10,
  parameter int ADDR_W      = 4,
  parameter int BRAM_LAT    = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK100MHZ,
  input  logic              reset_in_n,
  input  logic              start,
  input  logic [31:0]       expected_sum,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic              phase_tvalid,
  output logic [7:0]        phase_tdata,
  input  logic              dout_tvalid,
  input  logic [31:0]       dout_tdata,
  output logic [31:0]       sum,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic              error
);

  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NS  = CW'(NUM_SAMPLES);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     issue_cnt, ret_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [31:0]       exp_q;
  logic [BRAM_LAT:1] vld_pipe;
  logic              go, issue, ret, last_ret, tmo_hit;

  assign go       = start && (state == IDLE || state == DONE);
  assign issue    = (state == RUN) && (issue_cnt < NS);
  assign ret      = (state == RUN) && dout_tvalid;
  assign last_ret = ret && (ret_cnt == NS - CW'(1));
  // Abort on the edge where the idle count would reach TIMEOUT.
  assign tmo_hit  = (state == RUN) && !issue && !ret && (tmo_cnt == TMO - TW'(1));

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (go) state_nxt = RUN;
      RUN: begin
        if (last_ret)     state_nxt = CHECK;
        else if (tmo_hit) state_nxt = DONE;
      end
      CHECK:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == RUN) || (state == CHECK);
    bram_en      = issue;
    bram_addr    = issue ? issue_cnt[ADDR_W-1:0] : '0;
    phase_tvalid = vld_pipe[BRAM_LAT] && (state == RUN);
    phase_tdata  = phase_tvalid ? bram_dout : '0;
  end

  // Read-valid tracker: bit i is high i cycles after the address was issued.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= BRAM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
      tmo_cnt   <= '0;
      exp_q     <= '0;
      sum       <= '0;
      done      <= 1'b0;
      success   <= 1'b0;
      error     <= 1'b0;
    end else if (go) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
      tmo_cnt   <= '0;
      exp_q     <= expected_sum;
      sum       <= '0;
      done      <= 1'b0;
      success   <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (issue) issue_cnt <= issue_cnt + CW'(1);
          if (ret) begin
            sum     <= sum + dout_tdata;
            ret_cnt <= ret_cnt + CW'(1);
          end
          tmo_cnt <= (issue || ret) ? '0 : tmo_cnt + TW'(1);
          if (tmo_hit) begin
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        CHECK: begin
          done    <= 1'b1;
          success <= (sum == exp_q);
          error   <= (sum != exp_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_checksum_ctrl.sv
// Directed bench for sine_checksum_ctrl with BRAM/CORDIC models and a phase
// scoreboard; a second instance (NUM_SAMPLES=2) covers checksum wrap-around.
module tb_sine_checksum_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic [31:0] exp_sum, exp_sum2;
  logic        bram_en, bram_en2, phase_tvalid, phase_tvalid2, dout_tvalid, dout_tvalid2;
  logic [3:0]  bram_addr, bram_addr2;
  logic [7:0]  bram_dout, bram_dout2, phase_tdata, phase_tdata2;
  logic [31:0] dout_tdata, dout_tdata2, sum, sum2;
  logic        busy, done, success, error, busy2, done2, success2, error2;

  sine_checksum_ctrl dut (
    .CLK100MHZ(clk), .reset_in_n(rst_n), .start(start), .expected_sum(exp_sum),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .phase_tvalid(phase_tvalid), .phase_tdata(phase_tdata),
    .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata),
    .sum(sum), .busy(busy), .done(done), .success(success), .error(error));

  sine_checksum_ctrl #(.NUM_SAMPLES(2)) dut2 (
    .CLK100MHZ(clk), .reset_in_n(rst_n), .start(start2), .expected_sum(exp_sum2),
    .bram_en(bram_en2), .bram_addr(bram_addr2), .bram_dout(bram_dout2),
    .phase_tvalid(phase_tvalid2), .phase_tdata(phase_tdata2),
    .dout_tvalid(dout_tvalid2), .dout_tdata(dout_tdata2),
    .sum(sum2), .busy(busy2), .done(done2), .success(success2), .error(error2));

  // BRAM: latency 1, word k = k+1.
  always @(posedge clk) if (bram_en)  bram_dout  <= {4'd0, bram_addr}  + 8'd1;
  always @(posedge clk) if (bram_en2) bram_dout2 <= {4'd0, bram_addr2} + 8'd1;

  // CORDIC: latency 5, returns the phase; phase value drop_val is swallowed.
  logic [7:0] drop_val = 8'hFF;
  logic [4:0] cv = '0, cv2 = '0;
  logic [7:0] cd [0:4];
  always @(posedge clk) begin
    cv  <= {cv[3:0], phase_tvalid && (phase_tdata != drop_val)};
    cd[0] <= phase_tdata;
    for (int i = 1; i < 5; i++) cd[i] <= cd[i-1];
    cv2 <= {cv2[3:0], phase_tvalid2};
  end
  assign dout_tvalid  = cv[4];
  assign dout_tdata   = {24'd0, cd[4]};
  assign dout_tvalid2 = cv2[4];
  assign dout_tdata2  = 32'hFFFF_FFFF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errs = 0, s = 0, n_phase = 0, n0;
  int phase_q[$], cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: each phase must match the next queued value and cycle.
  always @(negedge clk) begin
    if (phase_tvalid) begin
      n_phase++;
      if (phase_q.size() == 0) chk("phase_unexpected", 32'(phase_tdata), 32'hDEAD);
      else begin
        chk("phase_data", 32'(phase_tdata), 32'(phase_q.pop_front()));
        chk("phase_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
      end
    end
  end

  task automatic go(input logic [31:0] e);
    @(negedge clk);
    exp_sum = e;
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < 10; k++) begin
      phase_q.push_back(k + 1);
      cyc_q.push_back(s + 2 + k);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic to_rel(input int r);
    while (cyc - s < r) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; exp_sum = '0; exp_sum2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sum", sum, 32'd0);
    chk("rst_ctl", 32'({bram_en, bram_addr, phase_tvalid, phase_tdata, busy, done, success, error}), 32'd0);
    chk("rst_ctl2", 32'({bram_en2, bram_addr2, phase_tvalid2, phase_tdata2, busy2, done2, success2, error2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass case
    go(32'd55);
    chk("run_first_addr", 32'({busy, bram_en, bram_addr}), 32'b110000);
    to_rel(7);  chk("sum_before_result", sum, 32'd0);
    to_rel(8);  chk("sum_after_result", sum, 32'd1);
    to_rel(17); chk("pass_pre_done", 32'({busy, done}), 32'b10);
    to_rel(18);
    chk("pass_flags", 32'({busy, done, success, error}), 32'b0110);
    chk("pass_sum", sum, 32'd55);
    chk("pass_queue", 32'(phase_q.size()), 32'd0);

    // Mismatch, started from DONE
    go(32'd54);
    chk("restart_clear", 32'({done, success, error}), 32'd0);
    chk("restart_sum", sum, 32'd0);
    to_rel(18);
    chk("mismatch_flags", 32'({busy, done, success, error}), 32'b0101);
    chk("mismatch_sum", sum, 32'd55);

    // Start during RUN is ignored
    n0 = n_phase;
    go(32'd55);
    to_rel(4); start = 1'b1; @(negedge clk); start = 1'b0;
    to_rel(18);
    chk("busy_start_flags", 32'({busy, done, success, error}), 32'b0110);
    chk("busy_start_sum", sum, 32'd55);
    chk("busy_start_phases", 32'(n_phase - n0), 32'd10);

    // Timeout: 10th result dropped, 9th result at cycle 15
    drop_val = 8'd10;
    go(32'd55);
    to_rel(270);
    chk("tmo_pre_done", 32'({busy, done}), 32'b10);
    chk("tmo_pre_sum", sum, 32'd45);
    to_rel(271);
    chk("tmo_flags", 32'({busy, done, success, error}), 32'b0101);
    chk("tmo_sum", sum, 32'd45);
    chk("tmo_queue", 32'(phase_q.size()), 32'd0);
    drop_val = 8'hFF;

    // Reset mid-run
    go(32'd55);
    to_rel(6); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_ctl", 32'({bram_en, bram_addr, phase_tvalid, phase_tdata, busy, done, success, error}), 32'd0);
    rst_n = 1'b1;
    phase_q.delete(); cyc_q.delete();
    n0 = n_phase;
    repeat (20) @(negedge clk);
    chk("midrst_no_phase", 32'(n_phase - n0), 32'd0);
    chk("midrst_idle_sum", sum, 32'd0);

    // Recovery run after reset
    go(32'd55);
    to_rel(18);
    chk("recover_flags", 32'({busy, done, success, error}), 32'b0110);
    chk("recover_sum", sum, 32'd55);

    // Wrap-around on the 2-sample instance
    @(negedge clk);
    exp_sum2 = 32'hFFFF_FFFE; start2 = 1'b1; s = cyc;
    @(negedge clk);
    start2 = 1'b0;
    to_rel(9);  chk("wrap_pre_done", 32'(done2), 32'd0);
    to_rel(10);
    chk("wrap_flags", 32'({busy2, done2, success2, error2}), 32'b0110);
    chk("wrap_sum", sum2, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
